led_mode_sequencer: RTL and testbench

The LED mode sequencer drives the eight board LEDs (LED1–LED8) on the iCE40HX8K board. It replaces the bare free-running counter with a controlled pattern engine. It contains a tick prescaler that paces pattern steps, and a debounced push-button that cycles through four display modes. It sits at top level between the board clock and button and the LED pins.

---
 rtl/led_mode_sequencer.sv | 169 ++++++++++++++++
 tb/tb_led_mode_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// led_mode_sequencer
//
// Pattern engine for the eight board LEDs. A prescaler paces pattern steps and
// a synchronized, debounced push-button cycles through four display modes:
// COUNT -> WALK -> BOUNCE -> BLINK -> COUNT.
//
// Parameters:
//   TICK_DIV         CLK cycles per pattern step (>= 2)
//   DEBOUNCE_CYCLES  consecutive cycles of a stable button level needed (>= 2)
//
// Ports:
//   CLK        board clock, all state updates on its rising edge
//   RST        asynchronous, active-high reset
//   BTN        raw push-button, active-high, asynchronous, may bounce
//   LED1..LED8 LEDn = pattern[n-1], straight from the pattern register
// -----------------------------------------------------------------------------
module led_mode_sequencer #(
  parameter int TICK_DIV        = 3_000_000,
  parameter int DEBOUNCE_CYCLES = 120_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7,
  output logic LED8
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    COUNT  = 2'd0,
    WALK   = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Button synchronizer and debouncer
  logic          s1, s2;
  logic          stable, stable_d;
  logic [DW-1:0] db_cnt;
  logic          press;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would collapse s1/s2 into
  // a single stage and break the synchronizer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      s1       <= BTN;
      s2       <= s1;
      stable_d <= stable;
      if (s2 != stable) begin
        // Accept the new level only after it has differed for DEBOUNCE_CYCLES
        // consecutive edges; any return to the old level restarts the count.
        if (db_cnt == DB_MAX) begin
          stable <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // One-cycle pulse on an accepted press; releases are ignored.
  assign press = stable & ~stable_d;

  // Mode FSM, pattern register and prescaler
  mode_e         mode_q, mode_d;
  dir_e          dir_q, dir_d;
  logic [7:0]    pattern_q, pattern_d;
  logic [TW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick = (presc_q == TICK_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q    <= COUNT;
      dir_q     <= DIR_LEFT;
      pattern_q <= 8'h00;
      presc_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      pattern_q <= pattern_d;
      presc_q   <= presc_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    mode_d    = mode_q;
    dir_d     = dir_q;
    pattern_d = pattern_q;
    presc_d   = tick ? '0 : presc_q + 1'b1;

    if (press) begin
      // A press beats a coincident tick: the step is dropped, the new mode
      // starts from its entry value and the step period restarts.
      presc_d = '0;
      dir_d   = DIR_LEFT;
      unique case (mode_q)
        COUNT:  begin mode_d = WALK;   pattern_d = 8'h01; end
        WALK:   begin mode_d = BOUNCE; pattern_d = 8'h01; end
        BOUNCE: begin mode_d = BLINK;  pattern_d = 8'hFF; end
        BLINK:  begin mode_d = COUNT;  pattern_d = 8'h00; end
      endcase
    end else if (tick) begin
      unique case (mode_q)
        COUNT:  pattern_d = pattern_q + 8'd1;
        WALK:   pattern_d = {pattern_q[6:0], pattern_q[7]};
        BOUNCE: begin
          // Reverse at either end instead of shifting out, so the end LEDs
          // are lit for exactly one step each.
          if (dir_q == DIR_LEFT) begin
            if (pattern_q == 8'h80) begin
              dir_d     = DIR_RIGHT;
              pattern_d = 8'h40;
            end else begin
              pattern_d = pattern_q << 1;
            end
          end else begin
            if (pattern_q == 8'h01) begin
              dir_d     = DIR_LEFT;
              pattern_d = 8'h02;
            end else begin
              pattern_d = pattern_q >> 1;
            end
          end
        end
        BLINK:  pattern_d = ~pattern_q;
      endcase
    end
  end

  assign LED1 = pattern_q[0];
  assign LED2 = pattern_q[1];
  assign LED3 = pattern_q[2];
  assign LED4 = pattern_q[3];
  assign LED5 = pattern_q[4];
  assign LED6 = pattern_q[5];
  assign LED7 = pattern_q[6];
  assign LED8 = pattern_q[7];

endmodule

// File: tb/tb_led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_mode_sequencer
//
// Directed bench for led_mode_sequencer with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Inputs are driven and LEDs sampled on the falling clock edge, so each wait
// of one falling edge spans exactly one rising (active) edge.
// -----------------------------------------------------------------------------
module tb_led_mode_sequencer;

  logic clk;
  logic rst;
  logic btn;
  logic led1, led2, led3, led4, led5, led6, led7, led8;
  logic [7:0] led;

  assign led = {led8, led7, led6, led5, led4, led3, led2, led1};

  led_mode_sequencer #(
    .TICK_DIV       (4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .BTN (btn),
    .LED1(led1),
    .LED2(led2),
    .LED3(led3),
    .LED4(led4),
    .LED5(led5),
    .LED6(led6),
    .LED7(led7),
    .LED8(led8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    int         edges;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input logic [7:0] act, input logic [7:0] exp, input string name);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: leds=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic b, input int e, input logic [7:0] x, input string name);
    vec_t v;
    v.btn   = b;
    v.edges = e;
    v.exp   = x;
    v.name  = name;
    vecs.push_back(v);
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // BOUNCE values after the first step following entry (0x01)
  logic [7:0] bounce_seq [14] = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    // Edge numbers in names/comments count rising edges after reset release.
    // 1: reset and COUNT, wrap after 1024 edges
    add(0, 3,    8'h00, "count_before_first_step");
    add(0, 1,    8'h01, "count_step1_e4");
    add(0, 4,    8'h02, "count_step2_e8");
    add(0, 1012, 8'hFF, "count_ff_e1020");
    add(0, 4,    8'h00, "count_wrap_e1024");
    // 2: two-cycle pulse rejected, COUNT continues
    add(1, 2,    8'h00, "short_pulse_e1026");
    add(0, 6,    8'h02, "short_pulse_ignored_e1032");
    // 2: 20-cycle hold -> one advance to WALK at k+5 (k = 1033)
    add(1, 4,    8'h03, "hold_count_step_e1036");
    add(1, 1,    8'h03, "hold_before_press_e1037");
    add(1, 1,    8'h01, "walk_entry_e1038");
    add(1, 14,   8'h08, "walk_held_e1052");
    // 3: WALK continues after release, wraps 0x80 -> 0x01
    add(0, 2,    8'h10, "walk_10");
    add(0, 4,    8'h20, "walk_20");
    add(0, 4,    8'h40, "walk_40");
    add(0, 4,    8'h80, "walk_80");
    add(0, 4,    8'h01, "walk_wrap_01_e1070");
    // 4: press to BOUNCE at 1076 (k = 1071); prescaler restarts on entry
    add(1, 5,    8'h02, "walk_before_bounce");
    add(1, 1,    8'h01, "bounce_entry_e1076");
    add(0, 3,    8'h01, "bounce_prescaler_cleared");
    add(0, 1,    8'h02, "bounce_02");
    for (int i = 0; i < 14; i++)
      add(0, 4, bounce_seq[i], $sformatf("bounce_step%0d", i));
    // 5: press to BLINK at 1142, then toggle every 4 edges
    add(1, 4,    8'h04, "bounce_before_blink");
    add(1, 1,    8'h04, "bounce_hold_before_blink");
    add(1, 1,    8'hFF, "blink_entry_e1142");
    add(0, 4,    8'h00, "blink_00");
    add(0, 4,    8'hFF, "blink_ff");
    add(0, 4,    8'h00, "blink_00_again");
    // 5: fourth press wraps to COUNT with 0x00 at 1160
    add(1, 4,    8'hFF, "blink_before_count");
    add(1, 1,    8'hFF, "blink_hold_before_count");
    add(1, 1,    8'h00, "count_entry_e1160");
    add(0, 3,    8'h00, "count_entry_hold");
    add(0, 1,    8'h01, "count_first_step_e1164");

    // Asynchronous reset must clear LEDs before any clock edge
    rst = 1'b0;
    btn = 1'b0;
    #1 rst = 1'b1;
    #1 check(led, 8'h00, "reset_async_no_edge");
    run_edges(2);
    check(led, 8'h00, "reset_held");
    rst = 1'b0;

    foreach (vecs[i]) begin
      btn = vecs[i].btn;
      run_edges(vecs[i].edges);
      check(led, vecs[i].exp, vecs[i].name);
    end

    // 6: press lands on the same edge as a COUNT tick (edge 1172)
    run_edges(2);
    btn = 1'b1;
    run_edges(5);
    check(led, 8'h02, "coincide_before");
    run_edges(1);
    check(led, 8'h01, "coincide_walk_entry_no_step");
    btn = 1'b0;
    run_edges(3);
    check(led, 8'h01, "coincide_hold_3_edges");
    run_edges(1);
    check(led, 8'h02, "coincide_next_step_4_edges");

    // 6: go to BOUNCE, then reset mid-BOUNCE with BTN held
    btn = 1'b1;
    run_edges(6);
    check(led, 8'h01, "bounce2_entry");
    run_edges(8);
    check(led, 8'h04, "bounce2_04");
    #2 rst = 1'b1;
    #1 check(led, 8'h00, "reset_mid_bounce_async");
    run_edges(2);
    check(led, 8'h00, "reset_mid_bounce_held");
    rst = 1'b0;
    // Held button re-accepted once: WALK entry on the sixth edge after
    // release (first edge after release = edge 1); COUNT steps at edge 4.
    run_edges(4);
    check(led, 8'h01, "post_reset_count_e4");
    run_edges(5);
    check(led, 8'h01, "post_reset_walk_hold_e9");
    run_edges(1);
    check(led, 8'h02, "post_reset_walk_step_e10");
    run_edges(4);
    check(led, 8'h04, "post_reset_walk_e14");
    btn = 1'b0;
    run_edges(4);
    check(led, 8'h08, "post_reset_walk_e18");
    run_edges(4);
    check(led, 8'h10, "post_reset_no_second_advance_e22");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
